// File: rtl/exe_stage.sv
// Execute stage: holds one decoded instruction, drives the ALU, and hands the
// result to the memory stage; multi-cycle results are buffered under backpressure.
module exe_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [18:0] ds_alu_op,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [4:0]  ds_dest,
  input  logic [0:0]  ds_gr_we,
  input  logic [31:0] ds_pc,
  output logic [18:0] alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  input  logic [0:0]  alu_complete,
  output logic        es_to_ms_valid,
  input  logic        ms_allowin,
  output logic [31:0] es_to_ms_result,
  output logic [4:0]  es_to_ms_dest,
  output logic [0:0]  es_to_ms_gr_we,
  output logic [31:0] es_to_ms_pc,
  output logic        es_fwd_valid,
  output logic        es_fwd_ready,
  output logic [4:0]  es_fwd_dest,
  output logic [31:0] es_fwd_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q;
  logic [18:0] op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [4:0]  dest_q;
  logic [0:0]  gr_we_q;
  logic [31:0] pc_q;
  logic [31:0] result_buf_q;

  logic alu_done;
  logic es_ready_go;
  logic accept;

  // An empty op has nothing to wait for, so it completes on arrival.
  assign alu_done    = alu_complete[0] | (op_q == '0);
  assign es_ready_go = (state_q == S_DONE) | ((state_q == S_BUSY) & alu_done);
  assign es_allowin  = (state_q == S_IDLE) | (es_ready_go & ms_allowin);
  assign accept      = ds_to_es_valid & es_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      dest_q       <= '0;
      gr_we_q      <= '0;
      pc_q         <= '0;
      result_buf_q <= '0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      dest_q       <= '0;
      gr_we_q      <= '0;
      pc_q         <= '0;
      result_buf_q <= '0;
    end else if (accept) begin
      state_q <= S_BUSY;
      op_q    <= ds_alu_op;
      src1_q  <= ds_src1;
      src2_q  <= ds_src2;
      dest_q  <= ds_dest;
      gr_we_q <= ds_gr_we;
      pc_q    <= ds_pc;
    end else begin
      case (state_q)
        S_BUSY: begin
          if (alu_done && ms_allowin) begin
            state_q <= S_IDLE;
          end else if (alu_done) begin
            // The ALU may pulse complete for one cycle only; keep its result.
            state_q      <= S_DONE;
            result_buf_q <= alu_result;
          end
        end
        S_DONE: begin
          if (ms_allowin) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_op   = (state_q == S_BUSY) ? op_q : '0;
  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;

  assign es_to_ms_valid  = es_ready_go & ~flush;
  assign es_to_ms_result = (state_q == S_DONE) ? result_buf_q : alu_result;
  assign es_to_ms_dest   = dest_q;
  assign es_to_ms_gr_we  = gr_we_q;
  assign es_to_ms_pc     = pc_q;

  assign es_fwd_valid = (state_q != S_IDLE) & gr_we_q[0] & (dest_q != '0) & ~flush;
  assign es_fwd_ready = es_ready_go;
  assign es_fwd_dest  = dest_q;
  assign es_fwd_data  = es_to_ms_result;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: behavioural ALU, scoreboard of expected deliveries,
// plus directed checks on handshake, backpressure, flush and reset.
module tb_exe_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [18:0] ds_alu_op;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  logic [4:0]  ds_dest;
  logic [0:0]  ds_gr_we;
  logic [31:0] ds_pc;
  logic [18:0] alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic [0:0]  alu_complete;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_to_ms_result;
  logic [4:0]  es_to_ms_dest;
  logic [0:0]  es_to_ms_gr_we;
  logic [31:0] es_to_ms_pc;
  logic        es_fwd_valid;
  logic        es_fwd_ready;
  logic [4:0]  es_fwd_dest;
  logic [31:0] es_fwd_data;
  logic        mul_pulse;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  localparam logic [18:0] OP_ADD = 19'h00001;
  localparam logic [18:0] OP_MUL = 19'h01000;
  localparam logic [18:0] OP_DIV = 19'h08000;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_alu_op       (ds_alu_op),
    .ds_src1         (ds_src1),
    .ds_src2         (ds_src2),
    .ds_dest         (ds_dest),
    .ds_gr_we        (ds_gr_we),
    .ds_pc           (ds_pc),
    .alu_op          (alu_op),
    .alu_src1        (alu_src1),
    .alu_src2        (alu_src2),
    .alu_result      (alu_result),
    .alu_complete    (alu_complete),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_to_ms_result (es_to_ms_result),
    .es_to_ms_dest   (es_to_ms_dest),
    .es_to_ms_gr_we  (es_to_ms_gr_we),
    .es_to_ms_pc     (es_to_ms_pc),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_ready    (es_fwd_ready),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: add is single-cycle, mul/div complete only on the bench's pulse.
  always_comb begin
    alu_result = alu_src1;
    if (alu_op[0])       alu_result = alu_src1 + alu_src2;
    else if (alu_op[12]) alu_result = alu_src1 * alu_src2;
    else if (alu_op[15]) alu_result = 32'h0000_0BAD;
  end
  assign alu_complete[0] = alu_op[0] | mul_pulse;

  function automatic logic [31:0] exp_res(input logic [18:0] op, input logic [31:0] s1,
                                           input logic [31:0] s2);
    if (op[0])  return s1 + s2;
    if (op[12]) return s1 * s2;
    return s1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] d, input logic we, input logic [31:0] pc);
    ds_to_es_valid = 1'b1;
    ds_alu_op      = op;
    ds_src1        = s1;
    ds_src2        = s2;
    ds_dest        = d;
    ds_gr_we       = we;
    ds_pc          = pc;
  endtask

  // Scoreboard: deliveries are checked before the same cycle's flush/accept.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      sb.delete();
    end else begin
      if (es_to_ms_valid && ms_allowin) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_result", es_to_ms_result, e.res);
          chk("sb_dest", {27'd0, es_to_ms_dest}, {27'd0, e.dest});
          chk("sb_pc", es_to_ms_pc, e.pc);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (ds_to_es_valid && es_allowin) begin
        e.res  = exp_res(ds_alu_op, ds_src1, ds_src2);
        e.dest = ds_dest;
        e.pc   = ds_pc;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; ms_allowin = 1'b1; mul_pulse = 1'b0;
    ds_to_es_valid = 1'b0; ds_alu_op = '0; ds_src1 = '0; ds_src2 = '0;
    ds_dest = '0; ds_gr_we = '0; ds_pc = '0;
    repeat (2) next();
    @(negedge clk);
    chk("rst_allowin", {31'd0, es_allowin}, 32'd1);
    chk("rst_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rst_alu_op", {13'd0, alu_op}, 32'd0);
    chk("rst_fwd_valid", {31'd0, es_fwd_valid}, 32'd0);
    chk("rst_fwd_ready", {31'd0, es_fwd_ready}, 32'd0);
    chk("rst_result", es_to_ms_result, 32'd0);
    chk("rst_pc", es_to_ms_pc, 32'd0);
    resetn = 1'b1;
    next();

    // Single-cycle add.
    issue(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 32'h100);
    next();
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("add_result", es_to_ms_result, 32'd12);
    chk("add_fwd_ready", {31'd0, es_fwd_ready}, 32'd1);
    chk("add_allowin", {31'd0, es_allowin}, 32'd1);
    chk("add_fwd_valid", {31'd0, es_fwd_valid}, 32'd1);
    chk("add_fwd_data", es_fwd_data, 32'd12);
    next();
    @(negedge clk);
    chk("add_idle_valid", {31'd0, es_to_ms_valid}, 32'd0);

    // Back-to-back adds.
    issue(OP_ADD, 32'd1, 32'd2, 5'd4, 1'b1, 32'h200);
    next();
    issue(OP_ADD, 32'd10, 32'd20, 5'd5, 1'b1, 32'h204);
    @(negedge clk);
    chk("b2b_valid0", {31'd0, es_to_ms_valid}, 32'd1);
    chk("b2b_allowin", {31'd0, es_allowin}, 32'd1);
    next();
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", {31'd0, es_to_ms_valid}, 32'd1);
    chk("b2b_result1", es_to_ms_result, 32'd30);
    next();
    @(negedge clk);
    chk("b2b_drain", {31'd0, es_to_ms_valid}, 32'd0);

    // Multiply under backpressure with a one-cycle completion pulse.
    ms_allowin = 1'b0;
    issue(OP_MUL, 32'd3, 32'd4, 5'd6, 1'b1, 32'h300);
    next();
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("mul_busy_op", {13'd0, alu_op}, {13'd0, OP_MUL});
    chk("mul_busy_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("mul_busy_allowin", {31'd0, es_allowin}, 32'd0);
    next();
    mul_pulse = 1'b1;
    @(negedge clk);
    chk("mul_pulse_valid", {31'd0, es_to_ms_valid}, 32'd1);
    next();
    mul_pulse = 1'b0;
    @(negedge clk);
    chk("mul_done_op", {13'd0, alu_op}, 32'd0);
    chk("mul_done_result", es_to_ms_result, 32'd12);
    chk("mul_done_allowin", {31'd0, es_allowin}, 32'd0);
    chk("mul_done_fwd_ready", {31'd0, es_fwd_ready}, 32'd1);
    repeat (2) next();
    @(negedge clk);
    chk("mul_hold_result", es_to_ms_result, 32'd12);
    ms_allowin = 1'b1;
    @(negedge clk);
    chk("mul_release_allowin", {31'd0, es_allowin}, 32'd1);
    next();
    @(negedge clk);
    chk("mul_drain", {31'd0, es_to_ms_valid}, 32'd0);

    // Flush during a divide that never completes; a same-cycle offer is refused.
    issue(OP_DIV, 32'd100, 32'd7, 5'd7, 1'b1, 32'h400);
    next();
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("div_busy_op", {13'd0, alu_op}, {13'd0, OP_DIV});
    chk("div_fwd_valid", {31'd0, es_fwd_valid}, 32'd1);
    next();
    next();
    flush = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 5'd9, 1'b1, 32'h404);
    @(negedge clk);
    chk("flush_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("flush_fwd_valid", {31'd0, es_fwd_valid}, 32'd0);
    next();
    flush = 1'b0;
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_op", {13'd0, alu_op}, 32'd0);
    chk("post_flush_allowin", {31'd0, es_allowin}, 32'd1);
    chk("post_flush_valid", {31'd0, es_to_ms_valid}, 32'd0);

    // Empty op passes the ALU output through on arrival.
    issue(19'd0, 32'h1234, 32'd0, 5'd8, 1'b1, 32'h500);
    next();
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("nop_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("nop_result", es_to_ms_result, 32'h1234);
    next();

    // Writes to r0 are never forwarded.
    issue(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b1, 32'h600);
    next();
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("r0_fwd_valid", {31'd0, es_fwd_valid}, 32'd0);
    chk("r0_valid", {31'd0, es_to_ms_valid}, 32'd1);
    next();

    // Reset while a buffered result waits; reset also beats a same-cycle offer.
    ms_allowin = 1'b0;
    issue(OP_MUL, 32'hDEADBEEF, 32'd1, 5'd9, 1'b1, 32'h700);
    next();
    ds_to_es_valid = 1'b0;
    next();
    mul_pulse = 1'b1;
    next();
    mul_pulse = 1'b0;
    @(negedge clk);
    chk("done_buf", es_to_ms_result, 32'hDEADBEEF);
    resetn = 1'b0;
    flush  = 1'b1;
    issue(OP_ADD, 32'd2, 32'd2, 5'd10, 1'b1, 32'h704);
    next();
    resetn = 1'b1;
    flush  = 1'b0;
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("rst2_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rst2_result", es_to_ms_result, 32'd0);
    chk("rst2_allowin", {31'd0, es_allowin}, 32'd1);
    chk("rst2_pc", es_to_ms_pc, 32'd0);
    ms_allowin = 1'b1;
    repeat (2) next();
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have clk, input, 1, clock; all state updates on posedge clk.
REQ-002 SHALL have resetn, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have flush, input, 1, kill the in-stage instruction (exception/branch redirect).
REQ-004 SHALL have ds_to_es_valid, input, 1, decode stage offers an instruction; es_allowin, output, 1, this stage can accept.
REQ-005 SHALL have ds_alu_op [18:0], ds_src1 [31:0], ds_src2 [31:0], ds_dest [4:0], ds_gr_we [0:0], ds_pc [31:0], inputs, decode payload; alu_op one-hot, bits 18:12 are mul/mulh/mulhu/div/divu/mod/modu.
REQ-006 SHALL have alu_op [18:0], alu_src1 [31:0], alu_src2 [31:0], outputs, drive the ALU; alu_result [31:0] and alu_complete [0:0], inputs, from the ALU.
REQ-007 SHALL have es_to_ms_valid, output, 1; ms_allowin, input, 1; es_to_ms_result [31:0], es_to_ms_dest [4:0], es_to_ms_gr_we [0:0], es_to_ms_pc [31:0], outputs, memory-stage payload.
REQ-008 SHALL have es_fwd_valid, es_fwd_ready, outputs, 1 each; es_fwd_dest [4:0] and es_fwd_data [31:0], outputs, bypass/hazard info for decode.

Function
REQ-009 SHALL hold a 3-state FSM: IDLE (no instruction), BUSY (ALU op issued, awaiting alu_complete), DONE (result captured in result_buf, awaiting ms_allowin).
REQ-010 SHALL define es_ready_go = (state==DONE) | (state==BUSY & alu_complete).
REQ-011 SHALL drive es_allowin = (state==IDLE) | (es_ready_go & ms_allowin), combinational.
REQ-012 SHALL, on posedge with ds_to_es_valid & es_allowin & ~flush, latch the full payload and enter BUSY.
REQ-013 SHALL transition BUSY->DONE when alu_complete & ~ms_allowin, capturing alu_result into result_buf on that edge.
REQ-014 SHALL transition BUSY or DONE -> IDLE when es_ready_go & ms_allowin and no new accept; to BUSY with new payload when a new accept occurs the same edge.
REQ-015 SHALL drive alu_op = latched op only in BUSY, else 19'b0, so multiply/divide units are not re-triggered after capture or after flush.
REQ-016 SHALL drive alu_src1/alu_src2 from the latched operands at all times (held stable during BUSY).
REQ-017 SHALL drive es_to_ms_valid = es_ready_go & ~flush; es_to_ms_result = result_buf in DONE, else alu_result; dest/gr_we/pc from latched payload.
REQ-018 SHALL drive es_fwd_valid = (state!=IDLE) & gr_we & (dest!=0); es_fwd_ready = es_ready_go; es_fwd_dest = dest; es_fwd_data = es_to_ms_result.
REQ-019 SHALL, when flush is high, go to IDLE next edge from any state, discard payload and result_buf, and accept nothing that edge; es_to_ms_valid and es_fwd_valid low in the flush cycle.
REQ-020 SHALL give single-cycle ops (alu_complete=1 combinationally) zero-wait: accept edge N, result to memory stage at edge N+1 when ms_allowin=1.
REQ-021 SHALL tolerate alu_complete pulsing only one cycle (multiply/divide); the result SHALL never be lost while ms_allowin is low.
REQ-022 SHALL treat alu_op==0 in BUSY as complete-on-arrival with result passed through unchanged.

Reset
REQ-023 SHALL, while resetn=0 at posedge, enter IDLE, clear result_buf and latched payload to 0.
REQ-024 SHALL output during/after reset: es_allowin=1, es_to_ms_valid=0, alu_op=0, es_fwd_valid=0, es_fwd_ready=0, all data outputs 0.
REQ-025 SHALL let reset override flush and accept in the same cycle.

Verification
REQ-026 Add: op=bit0, src1=5, src2=7, dest=3, ms_allowin=1 -> next cycle es_to_ms_valid=1, result=12, es_fwd_ready=1, es_allowin=1.
REQ-027 Mul backpressure: op=bit12, src1=3, src2=4, alu_complete pulses cycle 2 while ms_allowin=0 for 4 cycles -> state DONE, alu_op=0 from cycle 3, result 12 delivered when ms_allowin rises.
REQ-028 Back-to-back: two adds accepted on consecutive edges with ms_allowin=1 -> two es_to_ms_valid cycles, results in order, no bubble.
REQ-029 Flush mid-divide: op=bit15 in BUSY, flush=1 cycle 3 -> IDLE next edge, alu_op=0, no es_to_ms_valid for that instruction.
REQ-030 Reset mid-DONE: result_buf=0xDEADBEEF, resetn=0 one cycle -> IDLE, es_to_ms_valid=0, es_to_ms_result=0.
REQ-031 dest=0 with gr_we=1 -> es_fwd_valid=0 throughout.
